// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a shared UART transmitter with busy-handshake timeout.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 always win; default build is round-robin.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [1:0] grant,
    output logic       timeout_err
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;  // 1: requester 1 was served most recently
    logic       sel;             // 1: requester 1 is the candidate this cycle
    logic       frame_end;

    always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
        sel = !req0_valid;
`else
        sel = (req0_valid && req1_valid) ? !last_q : !req0_valid;
`endif
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        frame_end   = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                req0_ready = !rst && req0_valid && !sel;
                req1_ready = !rst && req1_valid && sel;
                if (req0_ready || req1_ready) begin
                    data_d  = sel ? req1_data : req0_data;
                    grant_d = sel ? 2'b10 : 2'b01;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                tx_start = !rst;
                cnt_d    = '0;
                state_d  = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TimeoutVal) begin
                        timeout_err = !rst;
                        frame_end   = 1'b1;
                    end
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    frame_end = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Completion and timeout both release the transmitter and record the owner.
        if (frame_end) begin
            state_d = StIdle;
            grant_d = 2'b00;
        end
    end

    assign last_d = frame_end ? grant_q[1] : last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= 8'h00;
            cnt_q   <= 8'h00;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign tx_data = data_q;
    assign grant   = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL set the max cycles to wait for tx_busy after tx_start (legal 1..255).
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req0_valid  in  1  requester 0 has a byte pending.
REQ-006 req0_data  in  8  requester 0 byte.
REQ-007 req0_ready  out  1  requester 0 byte accepted this cycle.
REQ-008 req1_valid / req1_data / req1_ready SHALL mirror the req0 ports: widths 1/8/1, directions in/in/out.
REQ-009 tx_busy  in  1  shared transmitter is serializing a frame.
REQ-010 tx_start  out  1  one-cycle launch pulse to the transmitter.
REQ-011 tx_data  out  8  byte for the transmitter; stable from tx_start until return to IDLE.
REQ-012 grant  out  2  one-hot owner of the transmitter; 2'b00 when idle.
REQ-013 timeout_err  out  1  one-cycle pulse when the transmitter fails to respond.

Function
REQ-014 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-015 IDLE: reqN_ready SHALL be driven combinationally high only for the selected requester, and only if its valid is high; the other ready SHALL be low.
REQ-016 Transfer SHALL occur on the edge where valid && ready: reqN_data latched into tx_data, grant set one-hot to N, state -> LAUNCH.
REQ-017 Selection when both are valid, round-robin: the requester not served last SHALL win; when only one is valid, it SHALL win.
REQ-018 LAUNCH: tx_start SHALL be 1 for exactly this one cycle; state -> WAIT_BUSY; timeout counter cleared to 0.
REQ-019 WAIT_BUSY: if tx_busy = 1, state -> WAIT_DONE.
REQ-020 WAIT_BUSY: otherwise the counter SHALL increment; when it reaches TIMEOUT_CYCLES, timeout_err pulses 1 cycle, grant -> 00 and state -> IDLE.
REQ-021 A timed-out requester SHALL still count as last served.
REQ-022 WAIT_DONE: on tx_busy = 0, state -> IDLE, grant -> 00, and last-served SHALL be updated to the current owner.
REQ-023 Both ready outputs SHALL be 0 in every state except IDLE; a valid arriving mid-frame SHALL be held off, not dropped.
REQ-024 Minimum byte-to-byte spacing SHALL be accept, LAUNCH, WAIT_BUSY (>=1), WAIT_DONE (>=1), IDLE accept: no back-to-back accept without a return to IDLE.
REQ-025 tx_start SHALL never assert outside LAUNCH, and SHALL never assert twice per accepted byte.
REQ-026 The timeout counter SHALL be 8 bits and SHALL not wrap; it is compared for equality only.
REQ-027 tx_busy already high in IDLE SHALL be ignored; the stale frame does not block arbitration.

Reset
REQ-028 On rst = 1, the block SHALL enter IDLE, with tx_start = 0, tx_data = 8'h00, grant = 2'b00, timeout_err = 0, counter = 0 and last-served = requester 1.
REQ-029 While rst = 1, both ready outputs SHALL be 0.
REQ-030 A reset mid-frame SHALL discard the captured byte with no tx_start and no error pulse.

Configuration
REQ-031 With ARB_FIXED_PRIORITY_EN defined, requester 0 SHALL always win when both are valid, and last-served SHALL be ignored.
REQ-032 Without ARB_FIXED_PRIORITY_EN, the round-robin rule of REQ-017 SHALL apply.

Verification
REQ-033 Single request: after reset, req0 sends 8'hA5 and the model raises busy 2 cycles after tx_start, for 11 cycles. Required: one tx_start, tx_data = A5, grant = 01, return to IDLE.
REQ-034 Contention, round-robin: both valid continuously, req0 = 8'h11, req1 = 8'h22. Required: launches in order 11, 22, 11, 22; grant alternates 01/10.
REQ-035 Contention with ARB_FIXED_PRIORITY_EN defined, same stimulus as REQ-034. Required: launches 11, 11, 11; req1_ready stays 0.
REQ-036 Timeout: tx_busy held 0, TIMEOUT_CYCLES = 16. Required: timeout_err pulses exactly 16 cycles after LAUNCH; next grant goes to the other pending requester.
REQ-037 Reset mid-frame: assert rst during WAIT_DONE. Required: next cycle grant = 00 and tx_start = 0; a new req1 byte 8'h3C is accepted first.
